// File: rtl/la_iosupply_seq.sv
// Power-domain sequencer for IO-ring supply cells: ramps domains up in ascending
// order with power-good supervision, ramps them down in descending order, and latches faults.
module la_iosupply_seq #(
    parameter int N       = 4,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N*CW-1:0] delay,
    input  logic [N-1:0]    pgood,
    output logic [N-1:0]    pwr_en,
    output logic            ready,
    output logic            busy,
    output logic            fault,
    output logic [3:0]      fault_id,
    output logic [2:0]      dbg_state
);

    localparam int            TW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [N-1:0]  ONE     = N'(1);
    localparam logic [3:0]    LAST    = 4'(N - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAMP    = 3'd1,
        S_WAIT_PG = 3'd2,
        S_ON      = 3'd3,
        S_DOWN    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t          r_state;
    logic [3:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_to;
    logic [N-1:0]    r_pg_m;
    logic [N-1:0]    r_pg_s;
    logic [N-1:0]    r_pwr_en;
    logic            r_ready;
    logic            r_busy;
    logic            r_fault;
    logic [3:0]      r_fault_id;

    logic [CW-1:0]   w_dly_cur;
    logic [CW-1:0]   w_dly_nxt;
    logic [CW-1:0]   w_dly_prv;
    logic            w_pg_cur;
    logic            w_early_hit;
    logic [3:0]      w_early_id;
    logic            w_any_hit;
    logic [3:0]      w_any_id;
    logic            w_flt_hit;
    logic [3:0]      w_flt_id;

    // Descending scan so the lowest failing domain is the one that sticks.
    always_comb begin
        w_dly_cur   = '0;
        w_dly_nxt   = '0;
        w_dly_prv   = '0;
        w_pg_cur    = 1'b0;
        w_early_hit = 1'b0;
        w_early_id  = '0;
        w_any_hit   = 1'b0;
        w_any_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (4'(i) == r_idx) begin
                w_dly_cur = delay[i*CW +: CW];
                w_pg_cur  = r_pg_s[i];
            end
            if (4'(i) == r_idx + 4'd1) w_dly_nxt = delay[i*CW +: CW];
            if (4'(i) + 4'd1 == r_idx) w_dly_prv = delay[i*CW +: CW];
            if (!r_pg_s[i]) begin
                w_any_hit = 1'b1;
                w_any_id  = 4'(i);
                if (4'(i) < r_idx) begin
                    w_early_hit = 1'b1;
                    w_early_id  = 4'(i);
                end
            end
        end
    end

    always_comb begin
        w_flt_hit = 1'b0;
        w_flt_id  = '0;
        case (r_state)
            S_RAMP: begin
                w_flt_hit = w_early_hit;
                w_flt_id  = w_early_id;
            end
            S_WAIT_PG: begin
                if (w_early_hit) begin
                    w_flt_hit = 1'b1;
                    w_flt_id  = w_early_id;
                end else if (!w_pg_cur && r_to == TO_LAST) begin
                    w_flt_hit = 1'b1;
                    w_flt_id  = r_idx;
                end
            end
            S_ON: begin
                w_flt_hit = w_any_hit;
                w_flt_id  = w_any_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_to       <= '0;
            r_pg_m     <= '0;
            r_pg_s     <= '0;
            r_pwr_en   <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_id <= '0;
        end else begin
            r_pg_m <= pgood;
            r_pg_s <= r_pg_m;
            if (w_flt_hit) begin
                r_state    <= S_FAULT;
                r_pwr_en   <= '0;
                r_ready    <= 1'b0;
                r_busy     <= 1'b0;
                r_fault    <= 1'b1;
                r_fault_id <= w_flt_id;
            end else if (!en && (r_state == S_RAMP || r_state == S_WAIT_PG || r_state == S_ON)) begin
                r_state  <= S_DOWN;
                r_pwr_en <= r_pwr_en & ~(ONE << r_idx);
                r_cnt    <= w_dly_cur;
                r_ready  <= 1'b0;
                r_busy   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (en) begin
                            r_state  <= S_RAMP;
                            r_idx    <= '0;
                            r_pwr_en <= ONE;
                            r_cnt    <= delay[CW-1:0];
                            r_busy   <= 1'b1;
                        end
                    end
                    S_RAMP: begin
                        if (r_cnt <= CW'(1)) begin
                            r_state <= S_WAIT_PG;
                            r_to    <= '0;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    S_WAIT_PG: begin
                        if (w_pg_cur) begin
                            if (r_idx == LAST) begin
                                r_state <= S_ON;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state  <= S_RAMP;
                                r_idx    <= r_idx + 4'd1;
                                r_pwr_en <= r_pwr_en | (ONE << (r_idx + 4'd1));
                                r_cnt    <= w_dly_nxt;
                            end
                        end else begin
                            r_to <= r_to + TW'(1);
                        end
                    end
                    S_DOWN: begin
                        if (r_cnt > CW'(1)) begin
                            r_cnt <= r_cnt - CW'(1);
                        end else if (r_idx == 4'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx    <= r_idx - 4'd1;
                            r_pwr_en <= r_pwr_en & ~(ONE << (r_idx - 4'd1));
                            r_cnt    <= w_dly_prv;
                        end
                    end
                    S_FAULT: begin
                        if (!en) begin
                            r_state    <= S_IDLE;
                            r_idx      <= '0;
                            r_fault    <= 1'b0;
                            r_fault_id <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pwr_en    = r_pwr_en;
    assign ready     = r_ready;
    assign busy      = r_busy;
    assign fault     = r_fault;
    assign fault_id  = r_fault_id;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_la_iosupply_seq.sv
// Directed bench for la_iosupply_seq (N=2, TIMEOUT=10): the driver pushes cycle-stamped
// expected output snapshots, and a negedge monitor pops and compares them.
module tb_la_iosupply_seq;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] delay;
    logic [1:0]  pgood;
    logic [1:0]  pwr_en;
    logic        ready;
    logic        busy;
    logic        fault;
    logic [3:0]  fault_id;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e;
    int d;

    // Snapshot layout: {pwr_en[1:0], ready, busy, fault, fault_id[3:0]}
    logic [8:0] exp_q[$];
    int         exp_cyc_q[$];
    string      exp_name_q[$];

    la_iosupply_seq #(.N(2), .CW(16), .TIMEOUT(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .delay    (delay),
        .pgood    (pgood),
        .pwr_en   (pwr_en),
        .ready    (ready),
        .busy     (busy),
        .fault    (fault),
        .fault_id (fault_id),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] pk(input logic [1:0] p, input logic r, input logic b,
                                      input logic f, input logic [3:0] id);
        return {p, r, b, f, id};
    endfunction

    task automatic push(input int c, input string nm, input logic [8:0] v);
        exp_cyc_q.push_back(c);
        exp_name_q.push_back(nm);
        exp_q.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick(1);
    endtask

    // Monitor
    always @(negedge clk) begin
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            logic [8:0] act;
            logic [8:0] ex;
            string      nm;
            int         c;
            act = {pwr_en, ready, busy, fault, fault_id};
            ex  = exp_q.pop_front();
            nm  = exp_name_q.pop_front();
            c   = exp_cyc_q.pop_front();
            n_checks++;
            if (c != cyc || act !== ex) begin
                n_fail++;
                $display("FAIL %s stamp=%0d cyc=%0d actual={pwr_en,ready,busy,fault,fid}=%b required=%b",
                         nm, c, cyc, act, ex);
            end
        end
    end

    // Stimulus
    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        pgood = 2'b00;
        delay = {16'd3, 16'd3};
        tick(3);
        push(cyc, "reset", pk(2'b00, 0, 0, 0, 4'd0));
        tick(1);
        rst   = 1'b0;
        pgood = 2'b11;
        tick(3);

        // Power-up with delay 3 on both domains
        en = 1'b1;
        e  = cyc + 1;
        push(e + 0, "up_e0", pk(2'b01, 0, 1, 0, 4'd0));
        push(e + 3, "up_e3", pk(2'b01, 0, 1, 0, 4'd0));
        push(e + 4, "up_e4", pk(2'b11, 0, 1, 0, 4'd0));
        push(e + 7, "up_e7", pk(2'b11, 0, 1, 0, 4'd0));
        push(e + 8, "up_on", pk(2'b11, 1, 0, 0, 4'd0));
        goto(e + 8);

        // Power-down from ON
        en = 1'b0;
        d  = cyc + 1;
        push(d + 0, "dn_d0", pk(2'b01, 0, 1, 0, 4'd0));
        push(d + 2, "dn_d2", pk(2'b01, 0, 1, 0, 4'd0));
        push(d + 3, "dn_d3", pk(2'b00, 0, 1, 0, 4'd0));
        push(d + 5, "dn_d5", pk(2'b00, 0, 1, 0, 4'd0));
        push(d + 6, "dn_idle", pk(2'b00, 0, 0, 0, 4'd0));
        goto(d + 6);
        tick(2);

        // pgood[0] pulse low in ON with en held high
        en = 1'b1;
        e  = cyc + 1;
        push(e + 8, "on_again", pk(2'b11, 1, 0, 0, 4'd0));
        goto(e + 8);
        pgood = 2'b10;
        push(e + 10, "pulse_pre", pk(2'b11, 1, 0, 0, 4'd0));
        push(e + 11, "pulse_flt", pk(2'b00, 0, 0, 1, 4'd0));
        goto(e + 11);
        pgood = 2'b11;
        push(e + 14, "flt_hold", pk(2'b00, 0, 0, 1, 4'd0));
        goto(e + 14);
        en = 1'b0;
        push(e + 15, "flt_clr", pk(2'b00, 0, 0, 0, 4'd0));
        goto(e + 15);
        tick(3);

        // pgood[1] loss and en=0 decided on the same edge: fault wins
        en = 1'b1;
        e  = cyc + 1;
        push(e + 8, "on_sim", pk(2'b11, 1, 0, 0, 4'd0));
        goto(e + 8);
        pgood = 2'b01;
        goto(e + 10);
        en = 1'b0;
        push(e + 11, "sim_flt", pk(2'b00, 0, 0, 1, 4'd1));
        push(e + 12, "sim_clr", pk(2'b00, 0, 0, 0, 4'd0));
        goto(e + 12);
        pgood = 2'b11;
        tick(3);

        // Timeout on domain 1 with pgood[1] stuck low
        pgood = 2'b01;
        tick(3);
        en = 1'b1;
        e  = cyc + 1;
        push(e + 4, "to_e4", pk(2'b11, 0, 1, 0, 4'd0));
        push(e + 16, "to_e16", pk(2'b11, 0, 1, 0, 4'd0));
        push(e + 17, "to_flt", pk(2'b00, 0, 0, 1, 4'd1));
        goto(e + 17);
        push(e + 20, "to_hold", pk(2'b00, 0, 0, 1, 4'd1));
        goto(e + 20);
        en = 1'b0;
        push(e + 21, "to_clr", pk(2'b00, 0, 0, 0, 4'd0));
        goto(e + 21);
        pgood = 2'b11;
        tick(3);

        // Abort during domain-1 ramp, en=1 ignored in DOWN, then resets mid-RAMP and mid-DOWN
        en = 1'b1;
        e  = cyc + 1;
        push(e + 4, "r5_e4", pk(2'b11, 0, 1, 0, 4'd0));
        goto(e + 4);
        en = 1'b0;
        push(e + 5, "abort", pk(2'b01, 0, 1, 0, 4'd0));
        goto(e + 6);
        en = 1'b1;
        push(e + 8, "abort_e8", pk(2'b00, 0, 1, 0, 4'd0));
        push(e + 10, "abort_e10", pk(2'b00, 0, 1, 0, 4'd0));
        push(e + 11, "abort_idle", pk(2'b00, 0, 0, 0, 4'd0));
        push(e + 12, "reup", pk(2'b01, 0, 1, 0, 4'd0));
        goto(e + 12);
        rst = 1'b1;
        push(e + 13, "rst_ramp", pk(2'b00, 0, 0, 0, 4'd0));
        goto(e + 13);
        rst = 1'b0;
        push(e + 14, "up_after_rst", pk(2'b01, 0, 1, 0, 4'd0));
        goto(e + 14);
        en = 1'b0;
        push(e + 15, "dn_after_rst", pk(2'b00, 0, 1, 0, 4'd0));
        goto(e + 15);
        rst = 1'b1;
        push(e + 16, "rst_down", pk(2'b00, 0, 0, 0, 4'd0));
        goto(e + 16);
        rst = 1'b0;
        tick(4);

        // delay=0 behaves as delay=1
        delay = 32'd0;
        en    = 1'b1;
        e     = cyc + 1;
        push(e + 1, "z_e1", pk(2'b01, 0, 1, 0, 4'd0));
        push(e + 2, "z_e2", pk(2'b11, 0, 1, 0, 4'd0));
        push(e + 3, "z_e3", pk(2'b11, 0, 1, 0, 4'd0));
        push(e + 4, "z_on", pk(2'b11, 1, 0, 0, 4'd0));
        goto(e + 4);
        en = 1'b0;
        d  = cyc + 1;
        push(d + 0, "z_d0", pk(2'b01, 0, 1, 0, 4'd0));
        push(d + 1, "z_d1", pk(2'b00, 0, 1, 0, 4'd0));
        push(d + 2, "z_idle", pk(2'b00, 0, 0, 0, 4'd0));
        goto(d + 2);
        tick(3);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
